// File: rtl/riscv_pkg.sv
// Shared core types and widths used by the writeback path and register file.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;
    // Age ranks and the round-robin pointer cover up to four requesters.
    localparam int unsigned AGE_W      = 2;
    localparam int unsigned PTR_W      = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational writeback grant: round-robin from rr_ptr_i, but a younger entry never
// overtakes an older one that targets the same register.
module wb_rr_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]                 valid_i,
    input  logic [NUM_REQ-1:0][AGE_W-1:0]      age_i,
    input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0] rd_i,
    input  logic [PTR_W-1:0]                   rr_ptr_i,
    output logic [NUM_REQ-1:0]                 grant_o
);

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    int unsigned        idx;

    always_comb begin
        eligible = valid_i;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (i != j && valid_i[i] && valid_i[j] && rd_i[i] == rd_i[j] &&
                    rd_i[i] != '0 && age_i[j] < age_i[i]) begin
                    eligible[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (int'(rr_ptr_i) + off) % NUM_REQ;
            if (!found && eligible[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file writeback port between NUM_REQ producers via one-entry buffers.
// Define RF_WB_BYPASS_EN to let a lone request write straight through when all buffers are empty.
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]       req_data,
    output logic                          rf_write_en,
    output logic [REG_ADDR_W-1:0]         rf_rd_addr,
    output logic [XLEN-1:0]               rf_rd_data,
    output logic [NUM_REGS-1:0]           pending_mask,
    output logic                          conflict
);

    wb_req_t [NUM_REQ-1:0]                 buf_q, buf_d, req_in;
    logic    [NUM_REQ-1:0]                 buf_v_q, buf_v_d, grant;
    logic    [NUM_REQ-1:0][AGE_W-1:0]      age_q, age_d;
    logic    [NUM_REQ-1:0][REG_ADDR_W-1:0] buf_rd;
    logic    [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic    [AGE_W-1:0]                   gnt_age, keep_cnt, ins_cnt;
    int unsigned                           vld_cnt;
    logic                                  byp_take;
    wb_req_t                               byp_req;
    int unsigned                           byp_idx;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_in[i].rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
            req_in[i].data = req_data[i*XLEN +: XLEN];
            buf_rd[i]      = buf_q[i].rd;
        end
    end

`ifdef RF_WB_BYPASS_EN
    int unsigned byp_cnt;

    always_comb begin
        byp_cnt = 0;
        byp_idx = 0;
        byp_req = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                byp_cnt = byp_cnt + 1;
                byp_idx = i;
                byp_req = req_in[i];
            end
        end
        byp_take = (buf_v_q == '0) && (byp_cnt == 1) && (byp_req.rd != '0);
    end
`else
    assign byp_take = 1'b0;
    assign byp_req  = '0;
    assign byp_idx  = 0;
`endif

    wb_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .valid_i (buf_v_q),
        .age_i   (age_q),
        .rd_i    (buf_rd),
        .rr_ptr_i(rr_ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        rf_write_en  = |grant;
        rf_rd_addr   = '0;
        rf_rd_data   = '0;
        pending_mask = '0;
        vld_cnt      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                rf_rd_addr = rf_rd_addr | buf_q[i].rd;
                rf_rd_data = rf_rd_data | buf_q[i].data;
            end
            if (buf_v_q[i]) begin
                pending_mask[buf_q[i].rd] = 1'b1;
                vld_cnt = vld_cnt + 1;
            end
            req_ready[i] = !buf_v_q[i] || grant[i];
        end
        if (byp_take) begin
            rf_write_en = 1'b1;
            rf_rd_addr  = byp_req.rd;
            rf_rd_data  = byp_req.data;
        end
        conflict = vld_cnt > 1;
    end

    always_comb begin
        buf_d    = buf_q;
        buf_v_d  = buf_v_q;
        age_d    = age_q;
        rr_ptr_d = rr_ptr_q;
        gnt_age  = '0;
        keep_cnt = '0;
        ins_cnt  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_age  = age_q[i];
                rr_ptr_d = PTR_W'((i + 1) % NUM_REQ);
            end
        end
        // Survivors younger than the drained entry move up one rank.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (buf_v_q[i] && !grant[i]) begin
                keep_cnt = keep_cnt + AGE_W'(1);
                if (|grant && age_q[i] > gnt_age) begin
                    age_d[i] = age_q[i] - AGE_W'(1);
                end
            end
            if (grant[i]) begin
                buf_v_d[i] = 1'b0;
            end
        end
        // Lower index inserts first, so it ranks older among simultaneous arrivals.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i] && req_in[i].rd != '0 && !byp_take) begin
                buf_v_d[i] = 1'b1;
                buf_d[i]   = req_in[i];
                age_d[i]   = keep_cnt + ins_cnt;
                ins_cnt    = ins_cnt + AGE_W'(1);
            end
        end
        if (byp_take) begin
            rr_ptr_d = PTR_W'((byp_idx + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q    <= '0;
            buf_v_q  <= '0;
            age_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            buf_q    <= buf_d;
            buf_v_q  <= buf_v_d;
            age_q    <= age_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default build, two requesters).
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [4:0]  rd0, rd1;
    logic [31:0] d0, d1;
    logic [9:0]  req_rd;
    logic [63:0] req_data;
    logic        rf_write_en;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic [31:0] pending_mask;
    logic        conflict;
    logic [31:0] rf_model [32];
    logic [1:0]  fire;
    int          total = 0;
    int          bad   = 0;
    int unsigned n0, n1;

    assign req_rd   = {rd1, rd0};
    assign req_data = {d1, d0};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_write_en) rf_model[rf_rd_addr] <= rf_rd_data;
    end

    regfile_wb_arbiter #(
        .NUM_REQ(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .rf_write_en (rf_write_en),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .pending_mask(pending_mask),
        .conflict    (conflict)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        rd0 = '0; rd1 = '0; d0 = '0; d1 = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_we", rf_write_en, 0);
        chk("rst_addr", rf_rd_addr, 0);
        chk("rst_data", rf_rd_data, 0);
        chk("rst_pend", pending_mask, 0);
        chk("rst_conf", conflict, 0);
        chk("rst_ready", req_ready, 2'b11);

        // single write, one-cycle latency
        req_valid = 2'b01; rd0 = 5'd5; d0 = 32'hDEADBEEF;
        chk("t1_we_pre", rf_write_en, 0);
        tick();
        req_valid = 2'b00;
        chk("t1_we", rf_write_en, 1);
        chk("t1_addr", rf_rd_addr, 5);
        chk("t1_data", rf_rd_data, 32'hDEADBEEF);
        chk("t1_pend", pending_mask, 32'h20);
        chk("t1_ready", req_ready, 2'b11);
        tick();
        chk("t1_we_after", rf_write_en, 0);
        chk("t1_pend_after", pending_mask, 0);

        // simultaneous accept, rr_ptr starts at 0
        do_reset();
        req_valid = 2'b11; rd0 = 5'd3; d0 = 32'h11; rd1 = 5'd4; d1 = 32'h22;
        tick();
        req_valid = 2'b00;
        chk("t2_addr0", rf_rd_addr, 3);
        chk("t2_data0", rf_rd_data, 32'h11);
        chk("t2_conf0", conflict, 1);
        chk("t2_pend0", pending_mask, 32'h18);
        chk("t2_ready0", req_ready, 2'b01);
        tick();
        chk("t2_addr1", rf_rd_addr, 4);
        chk("t2_data1", rf_rd_data, 32'h22);
        chk("t2_conf1", conflict, 0);
        chk("t2_pend1", pending_mask, 32'h10);
        tick();
        chk("t2_idle", rf_write_en, 0);

        // same rd from req1 then req0
        req_valid = 2'b10; rd1 = 5'd7; d1 = 32'hAA;
        tick();
        chk("t3_addr0", rf_rd_addr, 7);
        chk("t3_data0", rf_rd_data, 32'hAA);
        req_valid = 2'b01; rd0 = 5'd7; d0 = 32'hBB;
        chk("t3_ready", req_ready, 2'b11);
        tick();
        req_valid = 2'b00;
        chk("t3_data1", rf_rd_data, 32'hBB);
        tick();
        chk("t3_reg7", rf_model[7], 32'hBB);
        chk("t3_idle", rf_write_en, 0);

        // age override: rr_ptr points at the younger same-rd entry
        req_valid = 2'b01; rd0 = 5'd9; d0 = 32'h99;
        tick();
        chk("t4_addr9", rf_rd_addr, 9);
        req_valid = 2'b11; rd0 = 5'd7; d0 = 32'hCAFE0001; rd1 = 5'd7; d1 = 32'hCAFE0002;
        chk("t4_ready", req_ready, 2'b11);
        tick();
        req_valid = 2'b00;
        chk("t4_conf", conflict, 1);
        chk("t4_pend", pending_mask, 32'h80);
        chk("t4_addr", rf_rd_addr, 7);
        chk("t4_old_first", rf_rd_data, 32'hCAFE0001);
        tick();
        chk("t4_young_next", rf_rd_data, 32'hCAFE0002);
        tick();
        chk("t4_reg7", rf_model[7], 32'hCAFE0002);
        chk("t4_idle", rf_write_en, 0);

        // x0 write is accepted and dropped
        req_valid = 2'b01; rd0 = 5'd0; d0 = 32'hFFFF;
        chk("t5_ready", req_ready, 2'b11);
        tick();
        req_valid = 2'b00;
        chk("t5_we", rf_write_en, 0);
        chk("t5_pend", pending_mask, 0);
        chk("t5_conf", conflict, 0);

        // continuous back-pressure from both requesters
        n0 = 0; n1 = 0;
        req_valid = 2'b11; rd0 = 5'd10; rd1 = 5'd20; d0 = 32'h1000; d1 = 32'h2000;
        fire = req_valid & req_ready;
        tick();
        if (fire[0]) begin n0++; d0 = 32'h1000 + n0; end
        if (fire[1]) begin n1++; d1 = 32'h2000 + n1; end
        for (int j = 0; j < 8; j++) begin
            chk("t6_we", rf_write_en, 1);
            chk("t6_addr", rf_rd_addr, (j % 2 == 1) ? 20 : 10);
            chk("t6_data", rf_rd_data,
                (j % 2 == 1) ? 32'h2000 + j / 2 : 32'h1000 + j / 2);
            chk("t6_ready", req_ready, (j % 2 == 1) ? 2'b10 : 2'b01);
            fire = req_valid & req_ready;
            tick();
            if (fire[0]) begin n0++; d0 = 32'h1000 + n0; end
            if (fire[1]) begin n1++; d1 = 32'h2000 + n1; end
        end
        chk("t6_conf", conflict, 1);
        chk("t6_pend", pending_mask, 32'h0010_0400);

        // reset with both buffers full
        rst = 1'b1;
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
        chk("t7_we", rf_write_en, 0);
        chk("t7_pend", pending_mask, 0);
        chk("t7_ready", req_ready, 2'b11);
        chk("t7_conf", conflict, 0);
        tick();
        chk("t7_we_after", rf_write_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single writeback write port between NUM_REQ producers (index 0 = ALU, 1 = load/store unit).
- Each requester gets a one-entry holding buffer.
- A round-robin scheduler with an age override drains the buffers into the port, one write per cycle.
- Exports a pending-write mask so decode can stall on registers that have been accepted but not yet written.
- Sits between execute/memory writeback and register_file's writeback port.

Parameters:
NUM_REQ, 2, number of writeback requesters (2..4)
XLEN, 32, data width, from the shared package
REG_ADDR_W, 5, register index width, from the shared package

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  requester i presents a write
req_ready  output  NUM_REQ  requester i may hand over a write this cycle
req_rd  input  NUM_REQ x REG_ADDR_W  destination register per requester
req_data  input  NUM_REQ x XLEN  write data per requester
rf_write_en  output  1  write strobe to register file
rf_rd_addr  output  REG_ADDR_W  write address to register file
rf_rd_data  output  XLEN  write data to register file
pending_mask  output  2**REG_ADDR_W  bit r set while any buffer holds a write to r
conflict  output  1  pulses when more than one buffer is valid in a cycle

Behaviour:
- Reset (rst=1 at edge):
  - All buffers invalid; age bits cleared; rr_ptr=0.
  - Outputs resolve to rf_write_en=0, rf_rd_addr=0, rf_rd_data=0, pending_mask=0, conflict=0, req_ready=all 1.
- Reset mid-operation discards buffered writes; no partial write occurs.
- Handshake:
  - Transfer happens when req_valid[i] && req_ready[i] at a rising edge.
  - req_ready[i] = !buf_v[i] || grant[i], so a buffered entry can be drained and refilled in the same cycle.
  - Requesters must hold rd and data stable while valid and not ready.
- x0 writes: a transfer with req_rd=0 completes the handshake but is dropped; nothing is buffered and no pending bit is set.
- Latency: transfer at edge N → entry valid in cycle N+1 → if granted, write strobe is combinational in cycle N+1 and the register file commits at edge N+1→N+2.
- Outputs are combinational from buffer state and grant only, never directly from req_* inputs (except with the optional feature).
- Grant:
  - One grant among valid buffers, round-robin starting at rr_ptr.
  - After a grant to k, rr_ptr ← (k+1) mod NUM_REQ; with no grant, rr_ptr holds.
- Age override:
  - If two valid buffers hold the same nonzero rd, the older entry is granted first, regardless of rr_ptr.
  - Each buffer keeps an age rank: 0 = oldest. On insertion the new entry takes rank = count of currently valid, not-draining entries. On a drain, all younger ranks decrement.
  - Simultaneous insertions: lower index is older.
- rf_write_en = |grant. When no grant, rf_rd_addr and rf_rd_data are 0.
- pending_mask is the OR of one-hot(buf_rd[i]) over valid buffers. A register's bit is still set in the cycle its write is strobed.
- conflict = (popcount(buf_v) > 1).

Optional Feature:
RF_WB_BYPASS_EN:
- Defined: in a cycle where all buffers are empty and exactly one req_valid is high with nonzero rd, that request drives rf_write_en, rf_rd_addr and rf_rd_data combinationally, is not buffered, and still advances rr_ptr. Latency is 0 cycles and pending_mask stays 0 for it.
- Undefined: every write goes through a buffer, with 1-cycle latency.

Decomposition:
- Shared package (riscv_pkg) holds XLEN and REG_ADDR_W, plus a new packed struct wb_req_t {rd, data}.
- Natural sub-module: wb_rr_arbiter.
  - Inputs: valid vector, age ranks, rd vector, rr_ptr.
  - Output: one-hot grant.
  - Purely combinational; rr_ptr and buffer state stay in the parent.

Test Plan:
- Reset, then req0 valid with rd=5, data=0xDEADBEEF → next cycle rf_write_en=1, addr=5, data=0xDEADBEEF; pending_mask[5]=1 in that cycle only. With bypass enabled, the write appears in the same cycle.
- req0 (rd=3, 0x11) and req1 (rd=4, 0x22) accepted in the same cycle, rr_ptr=0 → writes rd3 then rd4 on consecutive cycles; conflict=1 for one cycle; rr_ptr ends at 0.
- Same-rd ordering: req1 (rd=7, 0xAA) accepted at cycle N, req0 (rd=7, 0xBB) at N+1 while req1 is still buffered (req0 buffer held) → 0xAA written before 0xBB; final reg7=0xBB.
- x0 drop: req0 rd=0, data=0xFFFF → ready=1, no rf_write_en, pending_mask=0.
- Back-pressure: both requesters hold valid continuously for 8 cycles with distinct rd → writes alternate 0,1,0,1…; ready never stalls a drained requester more than 1 cycle.
- Reset asserted while both buffers are valid → next cycle no write, pending_mask=0, req_ready all 1.
